// File: rtl/panel_cursor_ctrl_pkg.sv
// Shared constants and types for the front-panel cursor/switch controller.
// Scancodes come from the PS/2 set 2 make codes that hps_io forwards.
package panel_cursor_ctrl_pkg;

  typedef enum logic [1:0] {
    SW_CENTER = 2'b00,
    SW_UP     = 2'b01,
    SW_DOWN   = 2'b10
  } sw_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } mv_state_e;

  localparam int unsigned PS2_STROBE = 10;
  localparam int unsigned PS2_PRESS  = 9;
  localparam int unsigned PS2_EXT    = 8;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef struct packed {
    logic left;
    logic right;
    logic grp_up;
    logic grp_dn;
    logic act_up;
    logic act_dn;
  } key_t;

endpackage

// File: rtl/panel_cursor_ctrl_ps2_key_event.sv
// Detects a new ps2_key strobe toggle and decodes it into a one-hot key class.
// The first cycle after reset only captures the strobe, so a stale bus never fires.
module panel_cursor_ctrl_ps2_key_event
  import panel_cursor_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [10:0] ps2_key_i,
  output logic        key_ev_o,
  output logic        key_press_o,
  output key_t        key_o
);

  logic       strobe_q;
  logic       armed_q;
  logic [7:0] code;

  assign code = ps2_key_i[7:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      strobe_q <= ps2_key_i[PS2_STROBE];
      armed_q  <= 1'b1;
    end
  end

  always_comb begin
    key_o = '0;
    if (ps2_key_i[PS2_EXT]) begin
      case (code)
        SC_LEFT:  key_o.left   = 1'b1;
        SC_RIGHT: key_o.right  = 1'b1;
        SC_UP:    key_o.grp_up = 1'b1;
        SC_DOWN:  key_o.grp_dn = 1'b1;
        default:  ;
      endcase
    end else begin
      case (code)
        SC_A:     key_o.left   = 1'b1;
        SC_D:     key_o.right  = 1'b1;
        SC_W:     key_o.grp_up = 1'b1;
        SC_S:     key_o.grp_dn = 1'b1;
        SC_SPACE: key_o.act_up = 1'b1;
        SC_X:     key_o.act_dn = 1'b1;
        default:  ;
      endcase
    end
  end

  assign key_ev_o    = armed_q && (ps2_key_i[PS2_STROBE] != strobe_q) && (key_o != '0);
  assign key_press_o = ps2_key_i[PS2_PRESS];

endmodule

// File: rtl/panel_cursor_ctrl.sv
// Keyboard cursor with auto-repeat and the 2-bit state array of the panel switches.
//   state     | meaning
//   ST_IDLE   | no left/right key held
//   ST_DELAY  | move key held, waiting for the first auto-repeat
//   ST_REPEAT | move key held, stepping once per repeat period
module panel_cursor_ctrl
  import panel_cursor_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_SW         = 25,
  parameter int unsigned        GROUP_SPLIT    = 16,
  parameter logic [NUM_SW-1:0]  MOMENTARY_MASK = 25'h1FF0000,
  parameter int unsigned        REPEAT_DELAY   = 25_000_000,
  parameter int unsigned        REPEAT_PERIOD  = 6_250_000,
  localparam int unsigned       IW             = $clog2(NUM_SW)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [10:0]         ps2_key_i,
  output logic [IW-1:0]       cursor_index_o,
  output logic [2*NUM_SW-1:0] switches_status_o,
  output logic                sw_event_o,
  output logic [IW-1:0]       sw_event_index_o
);

  localparam int unsigned CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

  function automatic logic [IW-1:0] step_left(input logic [IW-1:0] c);
    return (c == '0) ? IW'(NUM_SW - 1) : c - IW'(1);
  endfunction

  function automatic logic [IW-1:0] step_right(input logic [IW-1:0] c);
    return (c == IW'(NUM_SW - 1)) ? '0 : c + IW'(1);
  endfunction

  logic key_ev;
  logic key_press;
  key_t key;

  panel_cursor_ctrl_ps2_key_event u_key_event (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .ps2_key_i   (ps2_key_i),
    .key_ev_o    (key_ev),
    .key_press_o (key_press),
    .key_o       (key)
  );

  mv_state_e     mv_q;
  logic [CW-1:0] cnt_q;
  logic          dir_right_q;
  logic          mv_key, mv_same, mv_restart, mv_stop, rep_step;

  assign mv_key     = key_ev && (key.left || key.right);
  assign mv_same    = (mv_q != ST_IDLE) && (key.right == dir_right_q);
  // A typematic re-press of the key already held must not restart the delay.
  assign mv_restart = mv_key && key_press && !mv_same;
  assign mv_stop    = mv_key && !key_press && mv_same;
  assign rep_step   = (mv_q != ST_IDLE) && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mv_q        <= ST_IDLE;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
    end else if (mv_restart) begin
      mv_q        <= ST_DELAY;
      cnt_q       <= DELAY_LOAD;
      dir_right_q <= key.right;
    end else if (mv_stop) begin
      mv_q  <= ST_IDLE;
      cnt_q <= '0;
    end else if (mv_q != ST_IDLE) begin
      if (cnt_q == '0) begin
        mv_q  <= ST_REPEAT;
        cnt_q <= PERIOD_LOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  logic [IW-1:0]       cursor_q, cursor_d;
  logic [2*NUM_SW-1:0] sw_q, sw_d;
  logic                ev_q, ev_d;
  logic [IW-1:0]       ev_idx_q, ev_idx_d;
  logic                held_q, held_d;
  logic                held_up_q, held_up_d;
  logic [IW-1:0]       held_idx_q, held_idx_d;

  always_comb begin
    cursor_d   = cursor_q;
    sw_d       = sw_q;
    ev_d       = 1'b0;
    ev_idx_d   = ev_idx_q;
    held_d     = held_q;
    held_up_d  = held_up_q;
    held_idx_d = held_idx_q;
    if (key_ev) begin
      if (mv_restart) begin
        cursor_d = key.right ? step_right(cursor_q) : step_left(cursor_q);
      end else if (key_press && key.grp_up) begin
        cursor_d = IW'(GROUP_SPLIT);
      end else if (key_press && key.grp_dn) begin
        cursor_d = '0;
      end
      if (key_press && (key.act_up || key.act_dn)) begin
        if (MOMENTARY_MASK[cursor_q]) begin
          // Clear the previously held switch first so a re-press on it lands on the new value.
          if (held_q) sw_d[{held_idx_q, 1'b0} +: 2] = SW_CENTER;
          sw_d[{cursor_q, 1'b0} +: 2] = key.act_up ? SW_UP : SW_DOWN;
          held_d     = 1'b1;
          held_up_d  = key.act_up;
          held_idx_d = cursor_q;
        end else if (key.act_up) begin
          sw_d[{cursor_q, 1'b0} +: 2] = (sw_q[{cursor_q, 1'b0} +: 2] == SW_UP) ? SW_CENTER : SW_UP;
        end else begin
          sw_d[{cursor_q, 1'b0} +: 2] = SW_CENTER;
        end
        ev_d = (sw_d[{cursor_q, 1'b0} +: 2] != sw_q[{cursor_q, 1'b0} +: 2]);
        if (ev_d) ev_idx_d = cursor_q;
      end else if (!key_press && held_q && (held_up_q ? key.act_up : key.act_dn)) begin
        sw_d[{held_idx_q, 1'b0} +: 2] = SW_CENTER;
        held_d = 1'b0;
        ev_d   = (sw_q[{held_idx_q, 1'b0} +: 2] != SW_CENTER);
        if (ev_d) ev_idx_d = held_idx_q;
      end
    end else if (rep_step) begin
      cursor_d = dir_right_q ? step_right(cursor_q) : step_left(cursor_q);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cursor_q   <= '0;
      sw_q       <= '0;
      ev_q       <= 1'b0;
      ev_idx_q   <= '0;
      held_q     <= 1'b0;
      held_up_q  <= 1'b0;
      held_idx_q <= '0;
    end else begin
      cursor_q   <= cursor_d;
      sw_q       <= sw_d;
      ev_q       <= ev_d;
      ev_idx_q   <= ev_idx_d;
      held_q     <= held_d;
      held_up_q  <= held_up_d;
      held_idx_q <= held_idx_d;
    end
  end

  assign cursor_index_o    = cursor_q;
  assign switches_status_o = sw_q;
  assign sw_event_o        = ev_q;
  assign sw_event_index_o  = ev_idx_q;

endmodule

// File: tb/tb_panel_cursor_ctrl.sv
// Scoreboard bench: stimulus queues expected cursor values and switch events with
// their due cycle; a negedge monitor pops and compares whenever the DUT shows one.
module tb_panel_cursor_ctrl;

  localparam int NSW = 25;
  localparam int IW  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [10:0]       ps2 = '0;
  logic [IW-1:0]     cur;
  logic [2*NSW-1:0]  status;
  logic              sw_ev;
  logic [IW-1:0]     sw_ev_idx;

  panel_cursor_ctrl #(
    .NUM_SW         (25),
    .GROUP_SPLIT    (16),
    .MOMENTARY_MASK (25'h1FF0000),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (4)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (rst_n),
    .ps2_key_i         (ps2),
    .cursor_index_o    (cur),
    .switches_status_o (status),
    .sw_event_o        (sw_ev),
    .sw_event_index_o  (sw_ev_idx)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int due; } cur_exp_t;
  typedef struct { int idx; int st; int due; } ev_exp_t;

  cur_exp_t cur_q[$];
  ev_exp_t  ev_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int prev_cur = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: cursor changes and switch events are matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cur = 0;
    end else begin
      if (int'(cur) != prev_cur) begin
        if (cur_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cursor_unexpected: got %0d expected no change (cycle %0d)", cur, cyc);
        end else begin
          cur_exp_t e;
          e = cur_q.pop_front();
          chk("cursor_value", 64'(cur), 64'(e.val));
          chk("cursor_cycle", 64'(cyc), 64'(e.due));
        end
        prev_cur = int'(cur);
      end
      if (sw_ev) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL event_unexpected: got index %0d expected no event (cycle %0d)", sw_ev_idx, cyc);
        end else begin
          ev_exp_t e;
          e = ev_q.pop_front();
          chk("event_index", 64'(sw_ev_idx), 64'(e.idx));
          chk("event_state", 64'(status[2*sw_ev_idx +: 2]), 64'(e.st));
          chk("event_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic key(input bit pr, input bit ext, input logic [7:0] code);
    ps2 = {~ps2[10], pr, ext, code};
    @(negedge clk);
  endtask

  // Press and release of a move key; expected cursor lands on the press edge.
  task automatic mv(input bit ext, input logic [7:0] code, input int exp);
    cur_q.push_back('{exp, cyc + 1});
    key(1'b1, ext, code);
    key(1'b0, ext, code);
  endtask

  // Action key; idx < 0 means no switch event is expected.
  task automatic act(input bit pr, input logic [7:0] code, input int idx, input int st);
    if (idx >= 0) ev_q.push_back('{idx, st, cyc + 1});
    key(pr, 1'b0, code);
  endtask

  initial begin
    int k0, k1;
    // Reset with a pending D-press on the bus: must not decode after release.
    tick(2);
    ps2 = {1'b1, 1'b1, 1'b0, 8'h23};
    tick(1);
    ps2[10] = 1'b0;
    tick(1);
    ps2[10] = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("reset_cursor", 64'(cur), 64'd0);
    chk("reset_status", 64'(status), 64'd0);
    chk("reset_event", 64'(sw_ev), 64'd0);

    // Single moves, wrap and group jumps, plain and extended codes.
    mv(1'b0, 8'h1C, 24);
    mv(1'b0, 8'h23, 0);
    mv(1'b0, 8'h1D, 16);
    mv(1'b0, 8'h1B, 0);
    mv(1'b1, 8'h74, 1);
    mv(1'b1, 8'h6B, 0);
    tick(2);

    // Hold D: steps at press, +10, +14, +18; released before the next one.
    k0 = cyc;
    cur_q.push_back('{1, k0 + 1});
    cur_q.push_back('{2, k0 + 11});
    cur_q.push_back('{3, k0 + 15});
    cur_q.push_back('{4, k0 + 19});
    key(1'b1, 1'b0, 8'h23);
    wait_cyc(k0 + 21);
    key(1'b0, 1'b0, 8'h23);
    tick(12);
    chk("hold_stop_cursor", 64'(cur), 64'd4);

    // Hold D, then press A: direction switches and the delay restarts.
    k0 = cyc;
    cur_q.push_back('{5, k0 + 1});
    key(1'b1, 1'b0, 8'h23);
    tick(1);
    k1 = cyc;
    cur_q.push_back('{4, k1 + 1});
    cur_q.push_back('{3, k1 + 11});
    key(1'b1, 1'b0, 8'h1C);
    wait_cyc(k1 + 5);
    key(1'b0, 1'b0, 8'h23);
    wait_cyc(k1 + 13);
    key(1'b0, 1'b0, 8'h1C);
    tick(8);
    chk("redir_cursor", 64'(cur), 64'd3);

    // Latching switch 3.
    act(1'b1, 8'h29, 3, 1);
    chk("latch_on_status", 64'(status), 64'h40);
    act(1'b0, 8'h29, -1, 0);
    act(1'b1, 8'h29, 3, 0);
    chk("latch_off_status", 64'(status), 64'h0);
    act(1'b0, 8'h29, -1, 0);
    act(1'b1, 8'h22, -1, 0);
    act(1'b0, 8'h22, -1, 0);
    act(1'b1, 8'h29, 3, 1);
    act(1'b0, 8'h29, -1, 0);
    act(1'b1, 8'h22, 3, 0);
    act(1'b0, 8'h22, -1, 0);

    // Momentary switch 17: release clears it even after the cursor moved.
    mv(1'b0, 8'h1D, 16);
    mv(1'b0, 8'h23, 17);
    act(1'b1, 8'h22, 17, 2);
    chk("mom_down_status", 64'(status), 64'(2) << 34);
    mv(1'b0, 8'h23, 18);
    act(1'b0, 8'h22, 17, 0);
    chk("mom_release_status", 64'(status), 64'h0);

    // Second action press while one is held hands over the hold.
    act(1'b1, 8'h29, 18, 1);
    mv(1'b0, 8'h1C, 17);
    act(1'b1, 8'h22, 17, 2);
    chk("handover_status", 64'(status), 64'(2) << 34);
    act(1'b0, 8'h29, -1, 0);
    act(1'b0, 8'h22, 17, 0);
    act(1'b1, 8'h29, 17, 1);
    act(1'b1, 8'h29, -1, 0);
    act(1'b0, 8'h29, 17, 0);

    // Reset while a momentary switch is held.
    mv(1'b0, 8'h1C, 16);
    act(1'b1, 8'h29, 16, 1);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("midreset_status", 64'(status), 64'h0);
    chk("midreset_cursor", 64'(cur), 64'd0);
    chk("midreset_event", 64'(sw_ev), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    act(1'b0, 8'h29, -1, 0);
    tick(5);
    chk("final_status", 64'(status), 64'h0);
    chk("final_cursor", 64'(cur), 64'd0);
    chk("cursor_queue_empty", 64'(cur_q.size()), 64'd0);
    chk("event_queue_empty", 64'(ev_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
